// File: rtl/line_buf_pkg.sv
// Shared types and constants for the line-buffer sequencer.
package line_buf_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam int LINE_LEN_DEF   = 73;
    localparam int FRAME_ROWS_DEF = 72;
    // Rows/cols skipped before the 3x3 neighbourhood is fully populated.
    localparam int WIN_MARGIN     = 2;

endpackage

// File: rtl/line_pos_counter.sv
// Raster column/row position counter; wraps at line end and clears after the last pixel.
module line_pos_counter #(
    parameter int LINE_LEN   = 73,
    parameter int FRAME_ROWS = 72,
    parameter int ADDR_W     = 7,
    parameter int ROW_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clear,
    output logic [ADDR_W-1:0] col,
    output logic [ROW_W-1:0]  row,
    output logic              col_wrap,
    output logic              last
);

    assign col_wrap = (col == ADDR_W'(LINE_LEN - 1));
    assign last     = col_wrap && (row == ROW_W'(FRAME_ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last) begin
                col <= '0;
                row <= '0;
            end else if (col_wrap) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Write sequencer and window strobe generator for two cascaded line buffers
// feeding a 3x3 edge-detect kernel.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int LINE_LEN   = LINE_LEN_DEF,
    parameter int FRAME_ROWS = FRAME_ROWS_DEF,
    parameter int ADDR_W     = 7,
    parameter int ROW_W      = 7,
    parameter int PIX_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic              win_ready,
    output logic              lb_write_en,
    output logic [ADDR_W-1:0] lb_wr_addr,
    output logic [PIX_W-1:0]  lb_wr_data,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [ROW_W-1:0]  win_row,
    output logic              win_eol,
    output logic              win_eof,
    output logic              frame_done,
    output logic              busy
);

    state_t            state;
    logic              accept;
    logic              start_frame;
    logic              col_wrap;
    logic              last;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;

    assign pix_ready   = ((state == FILL) || (state == RUN)) && win_ready;
    assign accept      = pix_valid && pix_ready;
    assign start_frame = start && (state == IDLE);

    assign lb_write_en = accept;
    assign lb_wr_addr  = col;
    assign lb_wr_data  = pix_data;

    line_pos_counter #(
        .LINE_LEN   (LINE_LEN),
        .FRAME_ROWS (FRAME_ROWS),
        .ADDR_W     (ADDR_W),
        .ROW_W      (ROW_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (accept),
        .clear    (start_frame),
        .col      (col),
        .row      (row),
        .col_wrap (col_wrap),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (accept && last) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else if (accept && col_wrap && (row == ROW_W'(WIN_MARGIN - 1))) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Window fields hold between accepts; only the strobe drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= accept && (row >= ROW_W'(WIN_MARGIN)) && (col >= ADDR_W'(WIN_MARGIN));
            if (accept) begin
                win_col <= col;
                win_row <= row;
                win_eol <= col_wrap;
                win_eof <= last;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl on a 5x4 frame, with a pixel-index reference model.
module tb_line_buf_ctrl;

    localparam int L  = 5;
    localparam int R  = 4;
    localparam int AW = 3;
    localparam int RW = 3;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, pix_valid, win_ready;
    logic [PW-1:0] pix_data;
    logic          pix_ready, lb_write_en, win_valid, win_eol, win_eof, frame_done, busy;
    logic [AW-1:0] lb_wr_addr, win_col;
    logic [RW-1:0] win_row;
    logic [PW-1:0] lb_wr_data;

    always #5 clk = ~clk;

    line_buf_ctrl #(
        .LINE_LEN(L), .FRAME_ROWS(R), .ADDR_W(AW), .ROW_W(RW), .PIX_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .win_ready(win_ready), .lb_write_en(lb_write_en),
        .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .win_valid(win_valid),
        .win_col(win_col), .win_row(win_row), .win_eol(win_eol), .win_eof(win_eof),
        .frame_done(frame_done), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 accepting, 2 done; n = pixels accepted this frame
    int m_phase = 0;
    int m_n     = 0;
    int e_col = 0, e_row = 0;
    bit e_wv = 0, e_eol = 0, e_eof = 0, e_fd = 0, e_busy = 0;
    bit r_rdy, r_we, r_busy;
    int win_cnt = 0, fd_cnt = 0;

    typedef struct {
        bit st, pv, wr;
        bit e_rdy, e_we, e_busy;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit st, input bit pv, input bit wr, input logic [PW-1:0] d);
        bit acc;
        int c, r;
        rst_n = rn; start = st; pix_valid = pv; win_ready = wr; pix_data = d;
        #1;
        c = m_n % L;
        r = m_n / L;
        acc = rn && pv && wr && (m_phase == 1);
        r_rdy = pix_ready;
        r_we  = lb_write_en;
        if (rn) begin
            chk("pix_ready", pix_ready, (m_phase == 1) && wr);
            chk("lb_write_en", lb_write_en, acc);
            if (acc) begin
                chk("lb_wr_addr", lb_wr_addr, c);
                chk("lb_wr_data", lb_wr_data, d);
            end
        end
        if (!rn) begin
            m_phase = 0; m_n = 0;
            e_wv = 0; e_col = 0; e_row = 0; e_eol = 0; e_eof = 0; e_fd = 0;
        end else begin
            e_wv = acc && r >= 2 && c >= 2;
            e_fd = acc && (m_n == L * R - 1);
            if (acc) begin
                e_col = c; e_row = r;
                e_eol = (c == L - 1);
                e_eof = (m_n == L * R - 1);
            end
            case (m_phase)
                0: if (st) m_phase = 1;
                1: if (e_fd) begin m_phase = 2; m_n = 0; end
                   else if (acc) m_n++;
                default: m_phase = 0;
            endcase
        end
        e_busy = (m_phase != 0);
        @(posedge clk);
        #1;
        r_busy = busy;
        chk("win_valid", win_valid, e_wv);
        chk("win_col", win_col, e_col);
        chk("win_row", win_row, e_row);
        chk("win_eol", win_eol, e_eol);
        chk("win_eof", win_eof, e_eof);
        chk("frame_done", frame_done, e_fd);
        chk("busy", busy, e_busy);
        win_cnt += int'(win_valid);
        fd_cnt  += int'(frame_done);
    endtask

    // mode 0: streaming, 1: pix_valid every other cycle, 2: backpressure at col 3, 3: start during RUN
    task automatic run_frame(input int mode);
        bit seen_done = 0;
        bit bp_done   = 0;
        bit pv;
        win_cnt = 0;
        fd_cnt  = 0;
        step(1, 1, 0, 1, $urandom);
        for (int i = 0; i < 400; i++) begin
            if (mode == 2 && m_n == 3 && !bp_done) begin
                repeat (3) step(1, 0, 1, 0, $urandom);
                bp_done = 1;
            end
            pv = (mode == 1) ? (i % 2 == 0) : 1'b1;
            step(1, (mode == 3 && m_n == 12), pv, 1, $urandom);
            if (m_phase == 2) seen_done = 1;
            if (seen_done && m_phase == 0) break;
        end
        chk("frame_complete", int'(seen_done && m_phase == 0), 1);
        chk("window_count", win_cnt, 6);
        chk("frame_done_count", fd_cnt, 1);
    endtask

    initial begin
        tbl[0] = '{st:0, pv:1, wr:1, e_rdy:0, e_we:0, e_busy:0};
        tbl[1] = '{st:0, pv:1, wr:0, e_rdy:0, e_we:0, e_busy:0};
        tbl[2] = '{st:1, pv:1, wr:1, e_rdy:0, e_we:0, e_busy:1};
        tbl[3] = '{st:0, pv:0, wr:1, e_rdy:1, e_we:0, e_busy:1};
        tbl[4] = '{st:0, pv:1, wr:0, e_rdy:0, e_we:0, e_busy:1};

        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);

        for (int i = 0; i < 5; i++) begin
            step(1, tbl[i].st, tbl[i].pv, tbl[i].wr, $urandom);
            chk("tbl_pix_ready", r_rdy, tbl[i].e_rdy);
            chk("tbl_write_en", r_we, tbl[i].e_we);
            chk("tbl_busy", r_busy, tbl[i].e_busy);
        end

        // Controller is already armed; the frame's start pulse is ignored.
        run_frame(0);
        step(1, 0, 0, 1, '0);
        run_frame(0);
        run_frame(2);
        run_frame(1);
        run_frame(3);

        // Abort at row 2 col 1, then a clean frame.
        win_cnt = 0;
        fd_cnt  = 0;
        step(1, 1, 0, 1, $urandom);
        for (int i = 0; i < 50 && m_n != 11; i++) step(1, 0, 1, 1, $urandom);
        chk("abort_position", m_n, 11);
        step(0, 0, 1, 1, $urandom);
        step(1, 0, 0, 1, $urandom);
        chk("abort_no_windows", win_cnt, 0);
        chk("abort_no_frame_done", fd_cnt, 0);
        run_frame(0);

        // Random handshake and stray start pulses over several frames.
        fd_cnt = 0;
        for (int i = 0; i < 3000 && fd_cnt < 3; i++)
            step(1, ($urandom % 8) == 0, $urandom % 2, ($urandom % 4) != 0, $urandom);
        chk("random_frames", fd_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
